wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage.sv | 54 +++++
 tb/tb_wb_stage.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: M/W pipeline register with register-file write port, W-to-M store bypass and retire/cycle counters.
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_m,
  input  logic [31:0] wb_m,
  input  logic        valid_m,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] inst_w,
  output logic [31:0] wb_w,
  output logic        valid_w,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data,
  output logic [31:0] wb_w_bypass,
  output logic        wm_bypass,
  output logic [63:0] instret,
  output logic [63:0] cycle
);
  localparam logic [31:0] NOP = 32'h00000013;
  logic [6:0] op;
  logic writes_rd;
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_w  <= NOP;
      wb_w    <= '0;
      valid_w <= 1'b0;
      instret <= '0;
      cycle   <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      if (valid_w && !stall) instret <= instret + 64'd1;
      if (flush) begin
        inst_w  <= NOP;
        wb_w    <= '0;
        valid_w <= 1'b0;
      end else if (!stall) begin
        inst_w  <= inst_m;
        wb_w    <= wb_m;
        valid_w <= valid_m;
      end
    end
  end
  assign op = inst_w[6:0];
  assign writes_rd = op == 7'b0000011 || op == 7'b0010011 || op == 7'b0010111 || op == 7'b0110011 ||
                     op == 7'b0110111 || op == 7'b1100111 || op == 7'b1101111;
  assign rf_we = valid_w && inst_w[11:7] != 5'd0 && writes_rd;
  assign rf_addr = inst_w[11:7];
  assign rf_data = wb_w;
  assign wb_w_bypass = wb_w;
  // Store in M reads rs2 from the value W is writing this same cycle
  assign wm_bypass = rf_we && valid_m && inst_m[6:0] == 7'b0100011 && inst_m[24:20] == inst_w[11:7];
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed plus randomized checks of wb_stage against an instruction-level reference model.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        reset, valid_m, stall, flush;
  logic [31:0] inst_m, wb_m;
  logic [31:0] inst_w, wb_w, rf_data, wb_w_bypass;
  logic        valid_w, rf_we, wm_bypass;
  logic [4:0]  rf_addr;
  logic [63:0] instret, cycle;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] m_inst, m_wb;
  logic        m_valid;
  logic [63:0] m_cyc, m_ir;
  logic [6:0]  ops [10] = '{7'h03, 7'h13, 7'h17, 7'h33, 7'h37, 7'h67, 7'h6f, 7'h23, 7'h63, 7'h73};

  wb_stage dut (
    .clk(clk), .reset(reset), .inst_m(inst_m), .wb_m(wb_m), .valid_m(valid_m),
    .stall(stall), .flush(flush), .inst_w(inst_w), .wb_w(wb_w), .valid_w(valid_w),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .wb_w_bypass(wb_w_bypass),
    .wm_bypass(wm_bypass), .instret(instret), .cycle(cycle)
  );

  always #5 clk = ~clk;

  function automatic logic exp_we();
    logic [6:0] op = m_inst[6:0];
    return m_valid && m_inst[11:7] != 5'd0 &&
           (op == 7'h03 || op == 7'h13 || op == 7'h17 || op == 7'h33 ||
            op == 7'h37 || op == 7'h67 || op == 7'h6f);
  endfunction

  function automatic logic exp_byp();
    return exp_we() && valid_m && inst_m[6:0] == 7'h23 && inst_m[24:20] == m_inst[11:7];
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".inst_w"}, {32'd0, inst_w}, {32'd0, m_inst});
    chk({tag, ".wb_w"}, {32'd0, wb_w}, {32'd0, m_wb});
    chk({tag, ".valid_w"}, {63'd0, valid_w}, {63'd0, m_valid});
    chk({tag, ".rf_we"}, {63'd0, rf_we}, {63'd0, exp_we()});
    chk({tag, ".rf_addr"}, {59'd0, rf_addr}, {59'd0, m_inst[11:7]});
    chk({tag, ".rf_data"}, {32'd0, rf_data}, {32'd0, m_wb});
    chk({tag, ".wb_w_bypass"}, {32'd0, wb_w_bypass}, {32'd0, m_wb});
    chk({tag, ".wm_bypass"}, {63'd0, wm_bypass}, {63'd0, exp_byp()});
    chk({tag, ".instret"}, instret, m_ir);
    chk({tag, ".cycle"}, cycle, m_cyc);
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] w, input logic v,
                       input logic s, input logic f, input logic r);
    inst_m = i; wb_m = w; valid_m = v; stall = s; flush = f; reset = r;
  endtask

  // Advance one edge: the model retires/loads per instruction, then outputs are compared
  task automatic step(string tag);
    @(posedge clk);
    if (reset) begin
      m_inst = 32'h13; m_wb = 0; m_valid = 0; m_cyc = 0; m_ir = 0;
    end else begin
      m_cyc = m_cyc + 1;
      if (m_valid && !stall) m_ir = m_ir + 1;
      if (flush) begin
        m_inst = 32'h13; m_wb = 0; m_valid = 0;
      end else if (!stall) begin
        m_inst = inst_m; m_wb = wb_m; m_valid = valid_m;
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    m_inst = 32'h13; m_wb = 0; m_valid = 0; m_cyc = 0; m_ir = 0;
    drive(32'hdeadbeef, 32'h55, 1, 1, 1, 1);
    #1;
    step("reset0");
    step("reset1");
    chk("reset.cycle_zero", cycle, 64'd0);
    drive(32'h00A00293, 32'd10, 1, 0, 0, 0);
    step("addi_x5");
    chk("addi.rf_we", {63'd0, rf_we}, 64'd1);
    chk("addi.rf_addr", {59'd0, rf_addr}, 64'd5);
    chk("addi.rf_data", {32'd0, rf_data}, 64'd10);
    drive(32'h13, 0, 0, 0, 0, 0);
    step("addi_retire");
    chk("addi.instret", instret, 64'd1);
    drive(32'h00100013, 32'd7, 1, 0, 0, 0);
    step("rd_x0");
    drive(32'h00112023, 32'd9, 1, 0, 0, 0);
    step("store");
    drive(32'h13, 0, 0, 0, 0, 0);
    step("x0_store_retire");
    chk("x0_store.instret", instret, 64'd3);
    drive(32'h00002083, 32'h1234, 1, 0, 0, 0);
    step("lw_x1");
    drive(32'h00112023, 32'h0, 1, 0, 0, 0);
    #1;
    check_all("sw_rs2_x1");
    chk("bypass.on", {63'd0, wm_bypass}, 64'd1);
    inst_m = 32'h00312023;
    #1;
    check_all("sw_rs2_x3");
    chk("bypass.off", {63'd0, wm_bypass}, 64'd0);
    drive(32'h00500313, 32'h77, 1, 0, 0, 0);
    step("addi_x6");
    drive(32'h00700393, 32'h99, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("stall");
    chk("stall.held", {32'd0, wb_w}, 64'h77);
    drive(32'h00700393, 32'h99, 1, 0, 0, 0);
    step("unstall");
    drive(32'h00800413, 32'haa, 1, 1, 1, 0);
    step("stall_flush");
    chk("stall_flush.valid_w", {63'd0, valid_w}, 64'd0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      ins[11:7] = 5'($urandom_range(0, 3));
      ins[24:20] = 5'($urandom_range(0, 3));
      drive(ins, $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 49) == 0));
      #1;
      check_all("rand_comb");
      step("rand");
    end
    drive(32'h00A00293, 32'd3, 1, 0, 0, 0);
    step("pre_reset");
    drive(32'h00A00293, 32'd3, 1, 1, 1, 1);
    step("mid_reset");
    chk("mid_reset.rf_we", {63'd0, rf_we}, 64'd0);
    drive(32'h00A00293, 32'd3, 1, 0, 0, 0);
    step("post_reset");
    chk("post_reset.cycle", cycle, 64'd1);
    @(negedge clk);
    force dut.cycle = '1;
    force dut.instret = '1;
    #1;
    release dut.cycle;
    release dut.instret;
    m_cyc = '1; m_ir = '1;
    step("wrap");
    chk("wrap.cycle", cycle, 64'd0);
    chk("wrap.instret", instret, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
